// File: rtl/uart_link_ctrl.sv
// uart_link_ctrl: frames 16-bit words over a byte UART as SYNC, hi, lo.
// RX parses received bytes into words on a valid/ready port. TX arbitrates
// two word requesters round-robin and feeds the transmitter one byte at a time.
// Optional build macro CHECKSUM_EN adds a fourth byte (hi ^ lo) to every frame.
module uart_link_ctrl #(
  parameter logic [7:0]  SYNC_BYTE   = 8'h80,
  parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_received,
  input  logic [7:0]  rx_byte,
  input  logic        recv_error,
  output logic        word_valid,
  output logic [15:0] word_data,
  input  logic        word_ready,
  output logic [7:0]  drop_cnt,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        uart_transmit,
  output logic [7:0]  uart_tx_byte,
  input  logic        uart_is_transmitting,
  output logic        tx_busy
);

  localparam logic [2:0] R_SYNC = 3'd0;
  localparam logic [2:0] R_HI   = 3'd1;
  localparam logic [2:0] R_LO   = 3'd2;
  localparam logic [2:0] R_OUT  = 3'd3;
`ifdef CHECKSUM_EN
  localparam logic [2:0] R_CHK  = 3'd4;
`endif

  localparam logic [2:0] T_IDLE = 3'd0;
  localparam logic [2:0] T_SYNC = 3'd1;
  localparam logic [2:0] T_HI   = 3'd2;
  localparam logic [2:0] T_LO   = 3'd3;
`ifdef CHECKSUM_EN
  localparam logic [2:0] T_CHK  = 3'd4;
`endif

  localparam logic [1:0] P_ISSUE = 2'd0;
  localparam logic [1:0] P_SKIP  = 2'd1;
  localparam logic [1:0] P_WAIT  = 2'd2;

  logic [2:0]  rx_state, rx_state_nx;
  logic [7:0]  hi_q, hi_nx, lo_q, lo_nx;
  logic [15:0] tmo_q, tmo_nx;
  logic        drop_inc;

  logic [2:0]  tx_state, tx_state_nx;
  logic [1:0]  tx_phase, tx_phase_nx;
  logic [15:0] tx_data, tx_data_nx;
  logic        rr_last, rr_last_nx;
  logic        gnt0_nx, gnt1_nx, xmit_nx, arb;
  logic [7:0]  tx_byte_nx, cur_byte;

  assign word_data = {hi_q, lo_q};

  // RX frame parser: next state, byte capture, inter-byte timeout, drop events
  always_comb begin
    rx_state_nx = rx_state;
    hi_nx       = hi_q;
    lo_nx       = lo_q;
    tmo_nx      = 16'd0;
    drop_inc    = 1'b0;
    case (rx_state)
      R_SYNC: begin
        if (rx_received && (rx_byte == SYNC_BYTE)) rx_state_nx = R_HI;
      end
      R_OUT: begin
        if (rx_received) drop_inc = 1'b1;
        if (word_valid && word_ready) rx_state_nx = R_SYNC;
      end
      R_HI, R_LO
`ifdef CHECKSUM_EN
      , R_CHK
`endif
      : begin
        if (recv_error) begin
          rx_state_nx = R_SYNC;
          drop_inc    = 1'b1;
        end else if (rx_received) begin
          if (rx_state == R_HI) begin
            hi_nx       = rx_byte;
            rx_state_nx = R_LO;
          end else if (rx_state == R_LO) begin
            lo_nx = rx_byte;
`ifdef CHECKSUM_EN
            rx_state_nx = R_CHK;
`else
            rx_state_nx = R_OUT;
`endif
          end
`ifdef CHECKSUM_EN
          else if (rx_byte == (hi_q ^ lo_q)) begin
            rx_state_nx = R_OUT;
          end else begin
            rx_state_nx = R_SYNC;
            drop_inc    = 1'b1;
          end
`endif
        end else if (tmo_q == TIMEOUT_CYC - 16'd1) begin
          rx_state_nx = R_SYNC;
          drop_inc    = 1'b1;
        end else begin
          tmo_nx = tmo_q + 16'd1;
        end
      end
      default: rx_state_nx = R_SYNC;
    endcase
  end

  // RX registers; word_valid tracks residency in R_OUT, drop_cnt saturates
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state   <= R_SYNC;
      hi_q       <= 8'd0;
      lo_q       <= 8'd0;
      tmo_q      <= 16'd0;
      word_valid <= 1'b0;
      drop_cnt   <= 8'd0;
    end else begin
      rx_state   <= rx_state_nx;
      hi_q       <= hi_nx;
      lo_q       <= lo_nx;
      tmo_q      <= tmo_nx;
      word_valid <= (rx_state_nx == R_OUT);
      if (drop_inc && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Byte carried by the current TX byte state
  always_comb begin
    case (tx_state)
      T_HI:    cur_byte = tx_data[15:8];
      T_LO:    cur_byte = tx_data[7:0];
`ifdef CHECKSUM_EN
      T_CHK:   cur_byte = tx_data[15:8] ^ tx_data[7:0];
`endif
      default: cur_byte = SYNC_BYTE;
    endcase
  end

  // TX sequencer: issue / skip / wait per byte, round-robin grant when idle
  always_comb begin
    tx_state_nx = tx_state;
    tx_phase_nx = tx_phase;
    tx_data_nx  = tx_data;
    rr_last_nx  = rr_last;
    gnt0_nx     = 1'b0;
    gnt1_nx     = 1'b0;
    xmit_nx     = 1'b0;
    tx_byte_nx  = uart_tx_byte;
    arb         = 1'b0;
    case (tx_state)
      T_IDLE: arb = 1'b1;
      default: begin
        case (tx_phase)
          P_ISSUE: begin
            xmit_nx     = 1'b1;
            tx_byte_nx  = cur_byte;
            tx_phase_nx = P_SKIP;
          end
          P_SKIP: tx_phase_nx = P_WAIT;
          default: begin
            if (!uart_is_transmitting) begin
              tx_phase_nx = P_ISSUE;
              case (tx_state)
                T_SYNC: tx_state_nx = T_HI;
                T_HI:   tx_state_nx = T_LO;
`ifdef CHECKSUM_EN
                T_LO:   tx_state_nx = T_CHK;
`endif
                default: begin
                  tx_state_nx = T_IDLE;
                  arb         = 1'b1;
                end
              endcase
            end
          end
        endcase
      end
    endcase
    // rr_last==1 means requester 1 was served last, so requester 0 wins a tie
    if (arb) begin
      if (req0 && (!req1 || rr_last)) begin
        gnt0_nx     = 1'b1;
        tx_data_nx  = data0;
        rr_last_nx  = 1'b0;
        tx_state_nx = T_SYNC;
        tx_phase_nx = P_ISSUE;
      end else if (req1) begin
        gnt1_nx     = 1'b1;
        tx_data_nx  = data1;
        rr_last_nx  = 1'b1;
        tx_state_nx = T_SYNC;
        tx_phase_nx = P_ISSUE;
      end
    end
  end

  // TX registers and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state      <= T_IDLE;
      tx_phase      <= P_ISSUE;
      tx_data       <= 16'd0;
      rr_last       <= 1'b1;
      gnt0          <= 1'b0;
      gnt1          <= 1'b0;
      uart_transmit <= 1'b0;
      uart_tx_byte  <= 8'd0;
      tx_busy       <= 1'b0;
    end else begin
      tx_state      <= tx_state_nx;
      tx_phase      <= tx_phase_nx;
      tx_data       <= tx_data_nx;
      rr_last       <= rr_last_nx;
      gnt0          <= gnt0_nx;
      gnt1          <= gnt1_nx;
      uart_transmit <= xmit_nx;
      uart_tx_byte  <= tx_byte_nx;
      tx_busy       <= (tx_state_nx != T_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_link_ctrl.sv
// Randomized bench for uart_link_ctrl: scenario-level RX model (expected words
// and drop count), TX requester/transmitter model with expected byte stream.
module tb_uart_link_ctrl;

  localparam logic [15:0] TB_TMO = 16'd64;
  localparam logic [7:0]  SYNC   = 8'h80;
  localparam int          NFRM   = 8;
`ifdef CHECKSUM_EN
  localparam int          FL     = 4;
`else
  localparam int          FL     = 3;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_received, recv_error, word_valid, word_ready;
  logic [7:0]  rx_byte, drop_cnt, uart_tx_byte;
  logic [15:0] word_data, data0, data1;
  logic        req0, req1, gnt0, gnt1, uart_transmit, uart_is_transmitting, tx_busy;

  int n_checks = 0;
  int n_errors = 0;
  int drops    = 0;

  uart_link_ctrl #(.SYNC_BYTE(SYNC), .TIMEOUT_CYC(TB_TMO)) dut (
    .clk(clk), .rst(rst),
    .rx_received(rx_received), .rx_byte(rx_byte), .recv_error(recv_error),
    .word_valid(word_valid), .word_data(word_data), .word_ready(word_ready),
    .drop_cnt(drop_cnt),
    .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1),
    .uart_transmit(uart_transmit), .uart_tx_byte(uart_tx_byte),
    .uart_is_transmitting(uart_is_transmitting), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_drop();
    return 32'((drops > 255) ? 255 : drops);
  endfunction

  function automatic logic [7:0] non_sync();
    logic [7:0] b;
    b = 8'($urandom);
    if (b == SYNC) b = 8'h81;
    return b;
  endfunction

  // one-cycle receiver event, returns at the falling edge after it was consumed
  task automatic rx_pulse(input logic [7:0] b, input logic rcv, input logic err);
    @(negedge clk);
    rx_received = rcv;
    rx_byte     = b;
    recv_error  = err;
    @(negedge clk);
    rx_received = 1'b0;
    recv_error  = 1'b0;
  endtask

  task automatic rx_gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  // full good frame; slow mode holds ready low and injects extra bytes
  task automatic rx_good(input logic [7:0] hi, input logic [7:0] lo, input bit slow,
                         input int extra, input logic [7:0] xb, input int hold, input int gapmax);
    logic [15:0] w;
    w = {hi, lo};
    word_ready = !slow;
    rx_pulse(SYNC, 1'b1, 1'b0);
    rx_gap($urandom_range(0, gapmax));
    rx_pulse(hi, 1'b1, 1'b0);
    rx_gap($urandom_range(0, gapmax));
`ifdef CHECKSUM_EN
    rx_pulse(lo, 1'b1, 1'b0);
    rx_gap($urandom_range(0, gapmax));
    check("rx_early_valid", 32'(word_valid), 32'd0);
    rx_pulse(hi ^ lo, 1'b1, 1'b0);
`else
    check("rx_early_valid", 32'(word_valid), 32'd0);
    rx_pulse(lo, 1'b1, 1'b0);
`endif
    check("rx_valid", 32'(word_valid), 32'd1);
    check("rx_data", 32'(word_data), 32'(w));
    if (!slow) begin
      @(negedge clk);
      check("rx_valid_once", 32'(word_valid), 32'd0);
    end else begin
      for (int k = 0; k < hold; k++) begin
        if (k < extra) begin
          rx_pulse(xb, 1'b1, 1'b0);
          drops++;
        end else begin
          rx_gap(1);
        end
        check("rx_hold_valid", 32'(word_valid), 32'd1);
        check("rx_hold_data", 32'(word_data), 32'(w));
      end
      word_ready = 1'b1;
      @(negedge clk);
      check("rx_accept", 32'(word_valid), 32'd0);
    end
    word_ready = 1'b0;
  endtask

  task automatic rx_thread();
    int kind, nb;
    logic [7:0] hi, lo;
    bit slow;
    int extra;
    // directed frames
    rx_good(8'h12, 8'h34, 1'b0, 0, 8'h00, 0, 2);
    check("rx_drop_first", 32'(drop_cnt), exp_drop());
    rx_good(8'hAB, 8'h80, 1'b1, 1, 8'h55, 20, 2);
    check("rx_drop_extra", 32'(drop_cnt), exp_drop());
    rx_pulse(SYNC, 1'b1, 1'b0);
    rx_pulse(8'h12, 1'b1, 1'b0);
    rx_gap(int'(TB_TMO) + 8);
    drops++;
    check("rx_tmo_valid", 32'(word_valid), 32'd0);
    rx_good(8'h56, 8'h78, 1'b0, 0, 8'h00, 0, 2);
    check("rx_drop_tmo", 32'(drop_cnt), exp_drop());
    rx_pulse(SYNC, 1'b1, 1'b0);
    rx_pulse(8'h00, 1'b0, 1'b1);
    drops++;
    rx_gap(2);
    check("rx_err_valid", 32'(word_valid), 32'd0);
    check("rx_drop_err", 32'(drop_cnt), exp_drop());
`ifdef CHECKSUM_EN
    rx_pulse(SYNC, 1'b1, 1'b0);
    rx_pulse(8'h12, 1'b1, 1'b0);
    rx_pulse(8'h34, 1'b1, 1'b0);
    rx_pulse(8'h27, 1'b1, 1'b0);
    drops++;
    rx_gap(2);
    check("rx_chk_valid", 32'(word_valid), 32'd0);
    check("rx_drop_chk", 32'(drop_cnt), exp_drop());
`endif
    // random scenarios
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 5);
      hi = ($urandom_range(0, 3) == 0) ? SYNC : 8'($urandom);
      lo = ($urandom_range(0, 3) == 0) ? SYNC : 8'($urandom);
      case (kind)
        0, 1: begin
          slow  = 1'($urandom_range(0, 1));
          extra = slow ? $urandom_range(0, 2) : 0;
          rx_good(hi, lo, slow, extra, 8'($urandom), extra + $urandom_range(1, 6),
                  ($urandom_range(0, 3) == 0) ? int'(TB_TMO) / 2 : 3);
        end
        2: begin
          repeat ($urandom_range(1, 3)) rx_pulse(non_sync(), 1'b1, 1'b0);
          rx_pulse(8'h00, 1'b0, 1'b1);
        end
        3: begin
          nb = $urandom_range(0, FL - 2);
          rx_pulse(SYNC, 1'b1, 1'b0);
          for (int j = 0; j < nb; j++) rx_pulse(8'($urandom), 1'b1, 1'b0);
          rx_pulse(8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
          drops++;
        end
        4: begin
          nb = $urandom_range(0, FL - 2);
          rx_pulse(SYNC, 1'b1, 1'b0);
          for (int j = 0; j < nb; j++) rx_pulse(8'($urandom), 1'b1, 1'b0);
          rx_gap(int'(TB_TMO) + 8);
          drops++;
        end
        default: begin
`ifdef CHECKSUM_EN
          rx_pulse(SYNC, 1'b1, 1'b0);
          rx_pulse(hi, 1'b1, 1'b0);
          rx_pulse(lo, 1'b1, 1'b0);
          rx_pulse(hi ^ lo ^ 8'($urandom_range(1, 255)), 1'b1, 1'b0);
          drops++;
`else
          rx_good(hi, lo, 1'b0, 0, 8'h00, 0, 3);
`endif
        end
      endcase
      rx_gap(1);
      check("rx_idle_valid", 32'(word_valid), 32'd0);
      check("rx_drop", 32'(drop_cnt), exp_drop());
    end
    // saturation of the drop counter
    rx_good(8'($urandom), 8'($urandom), 1'b1, 260, 8'($urandom), 265, 3);
    check("rx_drop_sat", 32'(drop_cnt), exp_drop());
  endtask

  task automatic tx_thread();
    logic [7:0]  exp_q[$];
    logic [15:0] dw;
    logic [7:0]  cur_b;
    logic        rp0, rp1, last, exp1;
    int left0, left1, dly0, dly1, busy_left, frames, cyc;
    left0 = NFRM; left1 = NFRM; dly0 = 0; dly1 = 0;
    busy_left = 0; frames = 0; cyc = 0; last = 1'b1; cur_b = 8'h00;
    req0 = 1'b1; req1 = 1'b1; data0 = 16'hBEEF; data1 = 16'hCAFE;
    rp0 = req0; rp1 = req1;
    while ((left0 > 0 || left1 > 0 || req0 || req1 || exp_q.size() > 0 || busy_left > 0)
           && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (gnt0 || gnt1) begin
        if (!rp0 && !rp1) begin
          check("tx_spurious_gnt", 32'({gnt1, gnt0}), 32'd0);
        end else begin
          exp1 = (rp0 && rp1) ? !last : !rp0;
          check("tx_gnt", 32'({gnt1, gnt0}), exp1 ? 32'd2 : 32'd1);
          check("tx_gnt_overlap", 32'(exp_q.size()), 32'd0);
          check("tx_busy_at_gnt", 32'(tx_busy), 32'd1);
          dw = exp1 ? data1 : data0;
          exp_q.push_back(SYNC);
          exp_q.push_back(dw[15:8]);
          exp_q.push_back(dw[7:0]);
`ifdef CHECKSUM_EN
          exp_q.push_back(dw[15:8] ^ dw[7:0]);
`endif
          last = exp1;
          frames++;
        end
      end
      // transmitter model
      if (uart_transmit) begin
        check("tx_issue_while_busy", 32'(busy_left), 32'd0);
        check("tx_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("tx_byte", 32'(uart_tx_byte), 32'(exp_q.pop_front()));
        cur_b = uart_tx_byte;
        busy_left = (frames <= 1) ? 10 : $urandom_range(1, 12);
        uart_is_transmitting = 1'b1;
      end else if (busy_left > 0) begin
        check("tx_byte_stable", 32'(uart_tx_byte), 32'(cur_b));
        busy_left--;
        if (busy_left == 0) uart_is_transmitting = 1'b0;
      end
      // requesters hold until granted, then re-request after a random delay
      if (gnt0) begin
        req0 = 1'b0;
        if (left0 > 0) left0--;
        dly0 = $urandom_range(0, 6);
      end else if (!req0 && left0 > 0) begin
        if (dly0 == 0) begin
          req0 = 1'b1;
          data0 = 16'($urandom);
        end else dly0--;
      end
      if (gnt1) begin
        req1 = 1'b0;
        if (left1 > 0) left1--;
        dly1 = $urandom_range(0, 6);
      end else if (!req1 && left1 > 0) begin
        if (dly1 == 0) begin
          req1 = 1'b1;
          data1 = 16'($urandom);
        end else dly1--;
      end
      rp0 = req0;
      rp1 = req1;
    end
    check("tx_frames", 32'(frames), 32'(2 * NFRM));
    check("tx_queue_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("tx_busy_end", 32'(tx_busy), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    rx_received = 1'b0; rx_byte = 8'h00; recv_error = 1'b0; word_ready = 1'b0;
    req0 = 1'b0; req1 = 1'b0; data0 = 16'h0; data1 = 16'h0; uart_is_transmitting = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_word_valid", 32'(word_valid), 32'd0);
    check("rst_word_data", 32'(word_data), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("rst_tx_outs", 32'({gnt0, gnt1, uart_transmit, tx_busy}), 32'd0);
    check("rst_tx_byte", 32'(uart_tx_byte), 32'd0);
    rst = 1'b1;
    fork
      rx_thread();
      tx_thread();
    join
    // reset in the middle of an RX frame and a TX frame
    rx_pulse(SYNC, 1'b1, 1'b0);
    rx_pulse(8'h12, 1'b1, 1'b0);
    req0 = 1'b1;
    data0 = 16'h1234;
    @(negedge clk);
    check("mid_gnt0", 32'({gnt1, gnt0}), 32'd1);
    req0 = 1'b0;
    @(negedge clk);
    check("mid_transmit", 32'(uart_transmit), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_transmit", 32'(uart_transmit), 32'd0);
    check("mid_rst_busy", 32'(tx_busy), 32'd0);
    check("mid_rst_drop", 32'(drop_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    rx_pulse(8'h34, 1'b1, 1'b0);
    check("mid_rst_no_word", 32'(word_valid), 32'd0);
    rx_gap(2);
    check("mid_rst_no_word2", 32'(word_valid), 32'd0);
    check("mid_rst_tx_idle", 32'(tx_busy), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_link_ctrl.md
Name: uart_link_ctrl

Overview:
- Sequences one byte-oriented UART transmitter/receiver pair for 16-bit word transport.
- RX side: parses frames of SYNC byte, high byte, low byte from the receiver and presents each 16-bit word on a valid/ready port. That port normally feeds the async FIFO write side.
- TX side: arbitrates two 16-bit word requesters round-robin and drives the transmitter byte-by-byte with the same framing.

Parameters:
- SYNC_BYTE, 8'h80, frame start marker.
- TIMEOUT_CYC, 16'd50000, max clk cycles between bytes of one RX frame before abort.

Ports:
- clk  in  1  single clock; all logic in this domain.
- rst  in  1  asynchronous, active-low reset.
- rx_received  in  1  one-cycle pulse: rx_byte valid (synchronous to clk).
- rx_byte  in  8  received byte.
- recv_error  in  1  one-cycle pulse: receiver framing error.
- word_valid  out  1  RX word available.
- word_data  out  16  RX word, {hi,lo}.
- word_ready  in  1  sink accepts the word (e.g. FIFO not full).
- drop_cnt  out  8  saturating count of discarded frames/bytes.
- req0, req1  in  1 each  TX requests.
- data0, data1  in  16 each  TX words; sampled at grant.
- gnt0, gnt1  out  1 each  one-cycle grant pulse; data latched.
- uart_transmit  out  1  one-cycle start pulse to the transmitter.
- uart_tx_byte  out  8  byte to transmit; stable from pulse until the byte completes.
- uart_is_transmitting  in  1  transmitter busy; rises the cycle after uart_transmit.
- tx_busy  out  1  TX FSM not in T_IDLE.

Behaviour:
- Reset: all outputs 0, RX FSM in R_SYNC, TX FSM in T_IDLE, rr pointer = 1 (req0 wins first tie), timeout counter 0.
- RX FSM states: R_SYNC, R_HI, R_LO, R_OUT.
  - R_SYNC: on rx_received with rx_byte==SYNC_BYTE, go to R_HI. Other bytes are ignored; no count.
  - R_HI: on byte, latch hi, go to R_LO.
  - R_LO: on byte, latch lo, go to R_OUT. word_valid=1 the following cycle.
  - SYNC_BYTE value in hi/lo position is data, not resync.
  - R_OUT: word_valid held with word_data stable until word_valid&word_ready, then R_SYNC next cycle. Any rx_received while in R_OUT: byte dropped, drop_cnt+1.
  - recv_error in R_HI/R_LO: return to R_SYNC, drop_cnt+1. If recv_error and rx_received occur in the same cycle, the error wins. recv_error in R_SYNC/R_OUT: ignored.
  - Timeout counter clears on every rx_received and counts in R_HI/R_LO. Reaching TIMEOUT_CYC: R_SYNC, drop_cnt+1.
  - drop_cnt saturates at 8'hFF.
- TX FSM states: T_IDLE, T_SYNC, T_HI, T_LO.
  - Each byte state has two phases:
    - ISSUE: uart_transmit=1 for one cycle.
    - WAIT: skip one cycle, then remain until uart_is_transmitting==0.
  - Byte order: SYNC_BYTE, data[15:8], data[7:0].
  - T_IDLE arbitration: one request: grant it. Both requests: grant the one not last granted.
  - Grant: gntN=1 for one cycle, data latched, rr pointer updated, enter T_SYNC ISSUE next cycle.
  - After the T_LO byte completes, return to T_IDLE. A new grant is possible in the same cycle.
  - Requests during a frame are held off; no grant until T_IDLE.
  - Minimum spacing: one grant per frame.
- RX and TX sides are fully independent; simultaneous activity is allowed.
- Reset mid-frame: frames abort immediately, no partial word output. uart_transmit drops to 0; the transmitter completes or resets on its own.

Optional Feature:
- CHECKSUM_EN defined:
  - Frames carry a 4th byte = hi^lo.
  - TX adds state T_CHK after T_LO.
  - RX adds state R_CHK after R_LO. Mismatch: R_SYNC, drop_cnt+1, no word_valid.
- Undefined: 3-byte frames exactly as above; no checksum states exist.

Test Plan:
- RX bytes 80,12,34 with word_ready=1 -> word_valid one cycle, word_data=16'h1234, drop_cnt=0.
- RX 80,AB,80 with word_ready=0 for 20 cycles, then extra byte 55 -> word_data=16'hAB80 held stable; 55 dropped, drop_cnt=1; word accepted when ready rises.
- RX 80,12 then no byte for TIMEOUT_CYC; then 80,56,78 -> drop_cnt=1; next word 16'h5678.
- RX 80 then recv_error pulse -> R_SYNC, drop_cnt=1, no word_valid.
- req0 and req1 held high, data0=16'hBEEF, data1=16'hCAFE, transmitter model busy 10 cycles per byte -> gnt0 first, then gnt1. Bytes in order 80,BE,EF,80,CA,FE. Each uart_transmit is issued only after is_transmitting falls.
- CHECKSUM_EN: TX 16'h1234 -> bytes 80,12,34,26. RX 80,12,34,27 -> no word, drop_cnt=1.
